duck_round_scheduler: RTL and testbench

Sequences gameplay while the game control FSM holds `game_enable`: spaces duck launches, grants a per-duck shot budget, times out escaping ducks, advances rounds, keeps the score and raises `game_finished` back to the control FSM. It sits between the control FSM and the duck/hit-detection datapath, all on the VGA pixel clock domain.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/game_tick_gen.sv | 35 +++
 rtl/duck_round_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_duck_round_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA duck game.
// Holds the round scheduler state encoding and the default game sizing
// constants used as parameter defaults by duck_round_scheduler.
package vga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_SPAWN,
    ST_ACTIVE,
    ST_RESOLVE,
    ST_DONE
  } round_state_t;

  localparam int ROUNDS_DEF          = 5;
  localparam int DUCKS_PER_ROUND_DEF = 4;
  localparam int SHOTS_PER_DUCK_DEF  = 3;
  localparam int SCORE_MAX           = 1023;

endpackage

// File: rtl/game_tick_gen.sv
// Game-second tick generator.
// Emits a one-cycle tick TICK_DIV cycles after restart and then every
// TICK_DIV cycles.
// Ports:
//   clk     in  pixel clock
//   rst     in  synchronous active-high reset
//   restart in  restarts the period; counter is zero in the next cycle
//   tick    out one-cycle pulse at the end of each period
module game_tick_gen #(
  parameter int TICK_DIV = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/duck_round_scheduler.sv
// Round scheduler for the duck game.
// Spaces duck launches, grants a shot budget per duck, times out escaping
// ducks, advances rounds, keeps a saturating score and reports the end of
// the game to the control FSM.
// Ports:
//   clk, rst             pixel clock, synchronous active-high reset
//   game_enable          level, gameplay allowed (low aborts to IDLE)
//   game_enable_posedge  one-cycle start pulse
//   left_mouse           raw mouse button level
//   duck_hit             one-cycle hit pulse from hit detection
//   duck_spawn           one-cycle duck launch pulse
//   duck_flee            one-cycle pulse sending the current duck away
//   duck_active          a duck is live and shootable
//   ammo                 remaining shots for the current duck
//   round                current round, 1-based, 0 when idle
//   score                accumulated points, saturating at SCORE_MAX
//   game_finished        level, held while the game is over
module duck_round_scheduler
  import vga_pkg::*;
#(
  parameter int TICK_DIV        = 65_000_000,
  parameter int ROUNDS          = ROUNDS_DEF,
  parameter int DUCKS_PER_ROUND = DUCKS_PER_ROUND_DEF,
  parameter int SHOTS_PER_DUCK  = SHOTS_PER_DUCK_DEF,
  parameter int SPAWN_GAP_S     = 1,
  parameter int DUCK_TIMEOUT_S  = 5,
  parameter int GRACE_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_enable,
  input  logic       game_enable_posedge,
  input  logic       left_mouse,
  input  logic       duck_hit,
  output logic       duck_spawn,
  output logic       duck_flee,
  output logic       duck_active,
  output logic [1:0] ammo,
  output logic [3:0] round,
  output logic [9:0] score,
  output logic       game_finished
);

  round_state_t r_state;
  logic         r_lm;
  logic         r_shot;
  logic [7:0]   r_sec;
  logic [7:0]   r_grace;
  logic [3:0]   r_count;
  logic         r_spawn;
  logic         r_flee;
  logic         r_active;
  logic [1:0]   r_ammo;
  logic [3:0]   r_round;
  logic [9:0]   r_score;
  logic         r_finished;

  logic w_tick;
  logic w_restart;
  logic w_gap_done;
  logic w_timeout;
  logic w_grace_out;
  logic w_last_duck;
  logic w_last_round;

  function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [3:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {7'd0, b};
    return (s > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : s[9:0];
  endfunction

  assign w_gap_done   = w_tick && (int'(r_sec) + 1 >= SPAWN_GAP_S);
  assign w_timeout    = w_tick && (int'(r_sec) + 1 >= DUCK_TIMEOUT_S);
  // Grace only matters once the shot budget is spent.
  assign w_grace_out  = (r_ammo == 2'd0) && (int'(r_grace) + 1 >= GRACE_CYCLES);
  assign w_last_duck  = (int'(r_count) + 1 >= DUCKS_PER_ROUND);
  assign w_last_round = (int'(r_round) >= ROUNDS);

  // The tick period restarts in the cycle that enters GAP or SPAWN, so the
  // spawn delay and the flee timeout line up with the registered outputs.
  always_comb begin
    w_restart = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: w_restart = game_enable_posedge;
      ST_GAP:           w_restart = game_enable && w_gap_done;
      ST_RESOLVE:       w_restart = !(w_last_duck && w_last_round);
      default:          w_restart = 1'b0;
    endcase
  end

  game_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(w_restart),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lm       <= 1'b0;
      r_shot     <= 1'b0;
      r_sec      <= '0;
      r_grace    <= '0;
      r_count    <= '0;
      r_spawn    <= 1'b0;
      r_flee     <= 1'b0;
      r_active   <= 1'b0;
      r_ammo     <= '0;
      r_round    <= '0;
      r_score    <= '0;
      r_finished <= 1'b0;
    end else begin
      // Shot edge detect: one register on the raw button level.
      r_lm    <= left_mouse;
      r_shot  <= left_mouse & ~r_lm;
      r_spawn <= 1'b0;
      r_flee  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (game_enable_posedge) begin
            r_round    <= 4'd1;
            r_count    <= '0;
            r_score    <= '0;
            r_finished <= 1'b0;
            r_sec      <= '0;
            r_state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (!game_enable) begin
            r_state <= ST_IDLE;
            r_round <= '0;
            r_ammo  <= '0;
          end else if (w_gap_done) begin
            r_spawn <= 1'b1;
            r_ammo  <= 2'(SHOTS_PER_DUCK);
            r_sec   <= '0;
            r_grace <= '0;
            r_state <= ST_SPAWN;
          end else if (w_tick) begin
            r_sec <= r_sec + 8'd1;
          end
        end
        ST_SPAWN: begin
          if (!game_enable) begin
            r_state <= ST_IDLE;
            r_round <= '0;
            r_ammo  <= '0;
          end else begin
            r_active <= 1'b1;
            r_state  <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (!game_enable) begin
            r_flee   <= 1'b1;
            r_active <= 1'b0;
            r_state  <= ST_IDLE;
            r_round  <= '0;
            r_ammo   <= '0;
          end else if (duck_hit) begin
            // A hit beats a flee condition raised in the same cycle.
            r_score  <= sat_add(r_score, r_round);
            r_active <= 1'b0;
            r_state  <= ST_RESOLVE;
          end else if (w_timeout || w_grace_out) begin
            r_flee   <= 1'b1;
            r_active <= 1'b0;
            r_state  <= ST_RESOLVE;
          end else begin
            if (w_tick) begin
              r_sec <= r_sec + 8'd1;
            end
            if (r_ammo == 2'd0) begin
              r_grace <= r_grace + 8'd1;
            end else if (r_shot) begin
              r_ammo <= r_ammo - 2'd1;
            end
          end
        end
        ST_RESOLVE: begin
          r_sec <= '0;
          if (w_last_duck) begin
            if (w_last_round) begin
              r_finished <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_round <= r_round + 4'd1;
              r_count <= '0;
              r_state <= ST_GAP;
            end
          end else begin
            r_count <= r_count + 4'd1;
            r_state <= ST_GAP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign duck_spawn    = r_spawn;
  assign duck_flee     = r_flee;
  assign duck_active   = r_active;
  assign ammo          = r_ammo;
  assign round         = r_round;
  assign score         = r_score;
  assign game_finished = r_finished;

endmodule

// File: tb/tb_duck_round_scheduler.sv
module tb_duck_round_scheduler;

  localparam int TD = 10, NR = 2, ND = 2, SH = 3, GAP = 1, TO = 5, GR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic ge, gep, lm, hit;
  logic spawn, flee, act, fin;
  logic [1:0] ammo;
  logic [3:0] rnd;
  logic [9:0] score;

  logic s_ge, s_gep, s_lm, s_hit;
  logic s_spawn, s_flee, s_act, s_fin;
  logic [1:0] s_ammo;
  logic [3:0] s_rnd;
  logic [9:0] s_score;

  duck_round_scheduler #(
    .TICK_DIV(TD), .ROUNDS(NR), .DUCKS_PER_ROUND(ND), .SHOTS_PER_DUCK(SH),
    .SPAWN_GAP_S(GAP), .DUCK_TIMEOUT_S(TO), .GRACE_CYCLES(GR)
  ) dut (
    .clk(clk), .rst(rst), .game_enable(ge), .game_enable_posedge(gep),
    .left_mouse(lm), .duck_hit(hit), .duck_spawn(spawn), .duck_flee(flee),
    .duck_active(act), .ammo(ammo), .round(rnd), .score(score),
    .game_finished(fin)
  );

  duck_round_scheduler #(
    .TICK_DIV(2), .ROUNDS(15), .DUCKS_PER_ROUND(15), .SHOTS_PER_DUCK(3),
    .SPAWN_GAP_S(1), .DUCK_TIMEOUT_S(5), .GRACE_CYCLES(4)
  ) dut_s (
    .clk(clk), .rst(rst), .game_enable(s_ge), .game_enable_posedge(s_gep),
    .left_mouse(s_lm), .duck_hit(s_hit), .duck_spawn(s_spawn), .duck_flee(s_flee),
    .duck_active(s_act), .ammo(s_ammo), .round(s_rnd), .score(s_score),
    .game_finished(s_fin)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int flee_count = 0;
  int s_at12 = -1;

  // Reference model: game phase plus absolute deadlines in cycles.
  localparam int M_IDLE = 0, M_GAP = 1, M_SPAWN = 2, M_ACTIVE = 3, M_RESOLVE = 4, M_DONE = 5;
  int   m_phase, m_round, m_count, m_score, m_ammo;
  int   m_spawn_at, m_flee_at, m_zero_at;
  logic m_lm, m_shot, e_spawn, e_flee, e_fin;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_round = 0; m_count = 0; m_score = 0; m_ammo = 0;
    m_spawn_at = 0; m_flee_at = 0; m_zero_at = 0;
    m_lm = 1'b0; m_shot = 1'b0; e_spawn = 1'b0; e_flee = 1'b0; e_fin = 1'b0;
  endtask

  task automatic abort_m(input logic from_active);
    m_phase = M_IDLE; m_round = 0; m_ammo = 0; e_flee = from_active;
  endtask

  // Inputs of cycle c -> expected outputs of cycle c+1.
  task automatic model_step();
    logic shot_now;
    int   c;
    c = cyc;
    shot_now = m_shot;
    m_shot = lm && !m_lm;
    m_lm = lm;
    e_spawn = 1'b0;
    e_flee = 1'b0;
    case (m_phase)
      M_IDLE, M_DONE: if (gep) begin
        m_round = 1; m_count = 0; m_score = 0; e_fin = 1'b0;
        m_phase = M_GAP; m_spawn_at = c + GAP * TD + 1;
      end
      M_GAP: if (!ge) abort_m(1'b0);
        else if (c + 1 == m_spawn_at) begin
          m_phase = M_SPAWN; e_spawn = 1'b1; m_ammo = SH; m_zero_at = 1 << 30;
        end
      M_SPAWN: if (!ge) abort_m(1'b0);
        else begin m_phase = M_ACTIVE; m_flee_at = c + TO * TD; end
      M_ACTIVE: begin
        if (!ge) abort_m(1'b1);
        else if (hit) begin
          m_score = (m_score + m_round > 1023) ? 1023 : m_score + m_round;
          m_phase = M_RESOLVE;
        end else if (c + 1 == m_flee_at || (m_ammo == 0 && c + 1 == m_zero_at + GR)) begin
          e_flee = 1'b1; m_phase = M_RESOLVE;
        end else if (shot_now && m_ammo > 0) begin
          m_ammo--;
          if (m_ammo == 0) m_zero_at = c + 1;
        end
      end
      M_RESOLVE: begin
        m_count++;
        m_spawn_at = c + GAP * TD + 1;
        if (m_count == ND) begin
          if (m_round == NR) begin m_phase = M_DONE; e_fin = 1'b1; end
          else begin m_round++; m_count = 0; m_phase = M_GAP; end
        end else m_phase = M_GAP;
      end
      default: m_phase = M_IDLE;
    endcase
  endtask

  task automatic clk_cycle();
    logic [19:0] got, exp;
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
    cyc++;
    got = {spawn, flee, act, ammo, rnd, score, fin};
    exp = {e_spawn, e_flee, (m_phase == M_ACTIVE), 2'(m_ammo), 4'(m_round), 10'(m_score), e_fin};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model cycle %0d: got %h expected %h", cyc, got, exp);
    end
    if (flee === 1'b1) flee_count++;
    if (s_rnd == 4'd12 && s_at12 < 0) s_at12 = int'(s_score);
  endtask

  task automatic idle_inputs();
    gep = 1'b0; lm = 1'b0; hit = 1'b0;
  endtask

  task automatic wait_spawn(input string name);
    int n;
    n = 0;
    while (spawn !== 1'b1 && n < 60) begin clk_cycle(); n++; end
    check(name, int'(spawn), 1);
  endtask

  typedef struct {
    int pre;
    logic ge, gep, lm, hit;
    logic sp, fl, ac;
    int am, rd, sc;
    logic fn;
  } vec_t;

  function automatic vec_t mk(input int pre, input logic g, gp, l, h, sp, fl, ac,
                              input int am, rd, sc, input logic fn);
    vec_t v;
    v.pre = pre; v.ge = g; v.gep = gp; v.lm = l; v.hit = h;
    v.sp = sp; v.fl = fl; v.ac = ac; v.am = am; v.rd = rd; v.sc = sc; v.fn = fn;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int sat_ok;
    int fc0;
    rst = 1'b1; ge = 1'b1; idle_inputs();
    s_ge = 1'b1; s_gep = 1'b0; s_lm = 1'b0; s_hit = 1'b0;
    model_reset();
    repeat (3) clk_cycle();
    check("reset spawn", int'(spawn), 0);
    check("reset flee", int'(flee), 0);
    check("reset active", int'(act), 0);
    check("reset ammo", int'(ammo), 0);
    check("reset round", int'(rnd), 0);
    check("reset score", int'(score), 0);
    check("reset finished", int'(fin), 0);
    rst = 1'b0;

    //             pre ge gp lm ht  sp fl ac am rd sc fn
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(9, 1, 0, 0, 0, 1, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 2, 1, 1, 0));
    tbl.push_back(mk(10, 1, 0, 0, 0, 1, 0, 0, 3, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 3, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 3, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 2, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(9, 1, 0, 0, 0, 1, 0, 0, 3, 2, 1, 0));
    tbl.push_back(mk(48, 1, 0, 0, 0, 0, 0, 1, 3, 2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 3, 2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3, 2, 1, 0));
    tbl.push_back(mk(9, 1, 0, 0, 0, 1, 0, 0, 3, 2, 1, 0));
    tbl.push_back(mk(48, 1, 0, 0, 0, 0, 0, 1, 3, 2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 3, 2, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3, 2, 3, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 3, 2, 3, 1));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].pre; k++) begin
        ge = tbl[i].ge; idle_inputs(); clk_cycle();
      end
      ge = tbl[i].ge; gep = tbl[i].gep; lm = tbl[i].lm; hit = tbl[i].hit;
      clk_cycle();
      check($sformatf("v%0d spawn", i), int'(spawn), int'(tbl[i].sp));
      check($sformatf("v%0d flee", i), int'(flee), int'(tbl[i].fl));
      check($sformatf("v%0d active", i), int'(act), int'(tbl[i].ac));
      check($sformatf("v%0d ammo", i), int'(ammo), tbl[i].am);
      check($sformatf("v%0d round", i), int'(rnd), tbl[i].rd);
      check($sformatf("v%0d score", i), int'(score), tbl[i].sc);
      check($sformatf("v%0d finished", i), int'(fin), int'(tbl[i].fn));
    end
    idle_inputs();

    // Full game restarted from DONE: four ducks, all hit.
    fc0 = flee_count;
    gep = 1'b1; clk_cycle(); gep = 1'b0;
    check("restart finished clear", int'(fin), 0);
    check("restart score clear", int'(score), 0);
    for (int d = 0; d < 4; d++) begin
      wait_spawn($sformatf("game duck%0d spawn", d));
      clk_cycle();
      hit = 1'b1; clk_cycle(); hit = 1'b0;
    end
    repeat (3) clk_cycle();
    check("game score", int'(score), 6);
    check("game round", int'(rnd), 2);
    check("game finished", int'(fin), 1);
    check("game no flee", flee_count, fc0);
    hit = 1'b1; clk_cycle(); hit = 1'b0; clk_cycle();
    check("done hit ignored", int'(score), 6);
    check("done held", int'(fin), 1);

    // Abort in ACTIVE after one hit.
    gep = 1'b1; clk_cycle(); gep = 1'b0;
    wait_spawn("abort spawn1");
    clk_cycle();
    hit = 1'b1; clk_cycle(); hit = 1'b0;
    wait_spawn("abort spawn2");
    repeat (2) clk_cycle();
    ge = 1'b0; clk_cycle();
    check("abort flee", int'(flee), 1);
    check("abort round", int'(rnd), 0);
    clk_cycle();
    check("abort flee single", int'(flee), 0);
    check("abort finished", int'(fin), 0);
    check("abort score held", int'(score), 1);
    check("abort active", int'(act), 0);
    ge = 1'b1; clk_cycle();

    // Saturation on the long-game instance: 15 rounds of 15 hit ducks.
    s_gep = 1'b1; clk_cycle(); s_gep = 1'b0;
    sat_ok = 1;
    for (int d = 0; d < 225; d++) begin
      int n;
      n = 0;
      while (s_spawn !== 1'b1 && n < 20) begin clk_cycle(); n++; end
      if (s_spawn !== 1'b1) begin sat_ok = 0; break; end
      clk_cycle();
      s_hit = 1'b1; clk_cycle(); s_hit = 1'b0;
    end
    check("sat spawn progress", sat_ok, 1);
    repeat (3) clk_cycle();
    check("sat score at round 12", s_at12, 990);
    check("sat score", int'(s_score), 1023);
    check("sat round", int'(s_rnd), 15);
    check("sat finished", int'(s_fin), 1);

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      ge  = ($urandom_range(0, 149) != 0);
      gep = ($urandom_range(0, 39) == 0);
      lm  = 1'($urandom_range(0, 1));
      hit = ($urandom_range(0, 24) == 0);
      clk_cycle();
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
